// File: rtl/pet2001_vram_arbiter_pkg.sv
// Shared widths, FSM state encoding and small helpers for the PET screen-RAM arbiter.
package pet2001_vram_pkg;

  localparam int unsigned VRAM_AW = 11;
  localparam int unsigned VRAM_DW = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VID_A = 3'd1,
    VID_D = 3'd2,
    CPU_A = 3'd3,
    CPU_D = 3'd4
  } state_e;

  // States in which the next RAM slot is allocated
  function automatic logic is_decision(input state_e s);
    return (s == IDLE) || (s == VID_D) || (s == CPU_D);
  endfunction

endpackage

// File: rtl/pet2001_vram_arbiter_if.sv
// Video-fetch, CPU-window and RAM-macro signals of the screen-RAM arbiter.
interface pet2001_vram_arbiter_if
  import pet2001_vram_pkg::*;
#(
  parameter int unsigned AW = VRAM_AW,
  parameter int unsigned DW = VRAM_DW
);

  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          vid_overrun;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  // Arbiter side
  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vid_data, vid_valid, vid_overrun, cpu_ack, cpu_rdata,
           ram_addr, ram_we, ram_wdata
  );

  // Video fetch, CPU decoder and RAM macro side
  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vid_data, vid_valid, vid_overrun, cpu_ack, cpu_rdata,
           ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/pet2001_vram_arbiter.sv
// Single-port screen-RAM arbiter: video fetch has absolute priority, CPU accesses
// fill the remaining slots through a req/ack handshake. All outputs are registered.
module pet2001_vram_arbiter
  import pet2001_vram_pkg::*;
#(
  parameter int unsigned AW = VRAM_AW,
  parameter int unsigned DW = VRAM_DW
) (
  input  logic                  clk,
  input  logic                  reset,
  pet2001_vram_arbiter_if.slave bus
);

  state_e        state_q, state_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic          overrun_q, overrun_d;

  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;

  logic [DW-1:0] vid_data_q, vid_data_d;
  logic          vid_valid_q, vid_valid_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic          cpu_wr_q, cpu_wr_d;

  logic          vid_want;
  logic          cpu_elig;
  logic [AW-1:0] vid_sel_addr;

  // A same-cycle vid_req counts as pending and its address wins over a stale one
  always_comb begin
    vid_want     = pend_q | bus.vid_req;
    vid_sel_addr = bus.vid_req ? bus.vid_addr : pend_addr_q;
    cpu_elig     = bus.cpu_req && (state_q != CPU_D) && !cpu_ack_q;
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    overrun_d   = overrun_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    vid_data_d  = vid_data_q;
    vid_valid_d = 1'b0;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    cpu_wr_d    = cpu_wr_q;

    if (bus.vid_req) begin
      pend_d      = 1'b1;
      pend_addr_d = bus.vid_addr;
      if (pend_q) begin
        overrun_d = 1'b1;
      end
    end

    unique case (state_q)
      VID_A: state_d = VID_D;
      CPU_A: state_d = CPU_D;
      VID_D: begin
        vid_data_d  = bus.ram_rdata;
        vid_valid_d = 1'b1;
      end
      CPU_D: begin
        if (!cpu_wr_q) begin
          cpu_rdata_d = bus.ram_rdata;
        end
        cpu_ack_d = 1'b1;
      end
      default: ;
    endcase

    // Slot allocation: video first, then an eligible CPU request
    if (is_decision(state_q)) begin
      if (vid_want) begin
        state_d    = VID_A;
        ram_addr_d = vid_sel_addr;
        pend_d     = 1'b0;
      end else if (cpu_elig) begin
        state_d     = CPU_A;
        ram_addr_d  = bus.cpu_addr;
        ram_we_d    = bus.cpu_we;
        ram_wdata_d = bus.cpu_wdata;
        cpu_wr_d    = bus.cpu_we;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      overrun_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      overrun_q   <= overrun_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_wr_q    <= cpu_wr_d;
    end
  end

  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.vid_data    = vid_data_q;
  assign bus.vid_valid   = vid_valid_q;
  assign bus.vid_overrun = overrun_q;
  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.cpu_rdata   = cpu_rdata_q;

endmodule
